// File: rtl/keycode_evt_pkg.sv
// Shared types for the keycode event queue: event word, FSM state names, "no key" code.
// Event word layout is {rpt, press, code}; rpt marks an auto-repeat press.
package keycode_evt_pkg;

  localparam logic [7:0] KC_NONE = 8'h00;

  typedef struct packed {
    logic       rpt;
    logic       press;
    logic [7:0] code;
  } kc_evt_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PRESS = 1'b1
  } kc_state_e;

  function automatic kc_evt_t kc_make_evt(input logic rpt, input logic press,
                                          input logic [7:0] code);
    kc_evt_t e;
    e.rpt   = rpt;
    e.press = press;
    e.code  = code;
    return e;
  endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// Show-ahead FIFO of key events; head visible the cycle after a push into an empty FIFO.
// Never back-pressures the writer: a push into a full FIFO without a same-edge pop is dropped and flagged.
module keycode_evt_fifo
  import keycode_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  kc_evt_t                  push_evt,
  input  logic                     pop_ready,
  output kc_evt_t                  head,
  output logic                     not_empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  kc_evt_t     mem [DEPTH];
  logic        pop;
  logic        accept;

  assign level     = wr_ptr - rd_ptr;
  assign not_empty = (level != '0);
  assign full      = (level == (AW+1)'(DEPTH));
  assign pop       = pop_ready && not_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign accept    = push && (!full || pop);
  assign drop      = push && !accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_evt;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign head = not_empty ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/keycode_event_queue.sv
// Turns the level keycode from the PIO into press/release events queued for a valid/ready consumer; 1-cycle latency.
// Never stalls on a full queue (drops set sticky overflow); KEYCODE_AUTOREPEAT_EN adds held-key repeat presses.
module keycode_event_queue
  import keycode_evt_pkg::*;
#(
  parameter int          DEPTH         = 8,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              keycode,
  input  logic                    evt_ready,
  input  logic                    ovf_clr,
  output logic                    evt_valid,
  output logic [7:0]              evt_code,
  output logic                    evt_press,
  output logic                    evt_repeat,
  output logic [7:0]              held_code,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow
);

  localparam logic [0:0] ST_IDLE  = 1'(IDLE);
  localparam logic [0:0] ST_PRESS = 1'(PRESS);

  logic [0:0] state;
  logic [7:0] committed;
  logic [7:0] pending;

  logic       chg_push;
  kc_evt_t    chg_evt;
  logic       push;
  kc_evt_t    push_evt;
  kc_evt_t    head;
  logic       fifo_full;
  logic       fifo_drop;

  always_comb begin
    chg_push = 1'b0;
    chg_evt  = '0;
    if (state == ST_PRESS) begin
      chg_push = 1'b1;
      chg_evt  = kc_make_evt(1'b0, 1'b1, pending);
    end else if (keycode != committed) begin
      chg_push = 1'b1;
      if (committed != KC_NONE) chg_evt = kc_make_evt(1'b0, 1'b0, committed);
      else                      chg_evt = kc_make_evt(1'b0, 1'b1, keycode);
    end
  end

  // A key-to-key change takes two cycles: release the old key, then press the new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      committed <= KC_NONE;
      pending   <= KC_NONE;
    end else if (state == ST_PRESS) begin
      committed <= pending;
      state     <= ST_IDLE;
    end else if (keycode != committed) begin
      if (committed == KC_NONE) begin
        committed <= keycode;
      end else if (keycode != KC_NONE) begin
        pending <= keycode;
        state   <= ST_PRESS;
      end else begin
        committed <= KC_NONE;
      end
    end
  end

`ifdef KEYCODE_AUTOREPEAT_EN
  logic [31:0] rpt_cnt;
  logic        rpt_run;
  logic        rpt_hit;

  // Counting only while the held key is stable also clears it on every commit.
  assign rpt_run = (state == ST_IDLE) && (keycode == committed) && (committed != KC_NONE);
  assign rpt_hit = rpt_run && ((rpt_cnt + 32'd1) == REPEAT_DELAY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
    end else if (!rpt_run) begin
      rpt_cnt <= '0;
    end else if (rpt_hit) begin
      rpt_cnt <= REPEAT_DELAY - REPEAT_PERIOD;
    end else begin
      rpt_cnt <= rpt_cnt + 32'd1;
    end
  end

  assign push     = chg_push || rpt_hit;
  assign push_evt = chg_push ? chg_evt : kc_make_evt(1'b1, 1'b1, committed);
`else
  assign push     = chg_push;
  assign push_evt = chg_evt;
`endif

  keycode_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_evt  (push_evt),
    .pop_ready (evt_ready),
    .head      (head),
    .not_empty (evt_valid),
    .full      (fifo_full),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (ovf_clr)   overflow <= 1'b0;
  end

  assign evt_code   = head.code;
  assign evt_press  = head.press;
`ifdef KEYCODE_AUTOREPEAT_EN
  assign evt_repeat = head.rpt;
`else
  assign evt_repeat = 1'b0;
`endif
  assign held_code  = committed;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Randomized and directed bench for keycode_event_queue against an event-list reference model.
module tb_keycode_event_queue;

  localparam int DEPTH = 4;
  localparam int RD    = 10;
  localparam int RP    = 4;
`ifdef KEYCODE_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [7:0]              keycode;
  logic                    evt_ready;
  logic                    ovf_clr;
  logic                    evt_valid;
  logic [7:0]              evt_code;
  logic                    evt_press;
  logic                    evt_repeat;
  logic [7:0]              held_code;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                    overflow;

  always #5 clk = ~clk;

  keycode_event_queue #(
    .DEPTH         (DEPTH),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .evt_ready  (evt_ready),
    .ovf_clr    (ovf_clr),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_press  (evt_press),
    .evt_repeat (evt_repeat),
    .held_code  (held_code),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the list of events the consumer should see, plus the held key.
  logic [9:0] q[$];
  logic [7:0] m_comm;
  logic [7:0] m_pend;
  bit         m_pend_vld;
  bit         m_ovf;
  int         edge_cnt;
  int         m_cedge;

  task automatic model_reset();
    q.delete();
    m_comm     = 8'h00;
    m_pend     = 8'h00;
    m_pend_vld = 1'b0;
    m_ovf      = 1'b0;
    edge_cnt   = 0;
    m_cedge    = 0;
  endtask

  task automatic model_edge();
    bit         pop;
    bit         ok;
    bit         push;
    logic [9:0] ev;
    int         t;
    pop  = evt_ready && (q.size() > 0);
    push = 1'b0;
    ev   = '0;
    if (m_pend_vld) begin
      push = 1'b1; ev = {2'b01, m_pend};
      m_comm = m_pend; m_pend_vld = 1'b0; m_cedge = edge_cnt;
    end else if (keycode != m_comm) begin
      push = 1'b1;
      if (m_comm != 8'h00) begin
        ev = {2'b00, m_comm};
        if (keycode != 8'h00) begin m_pend = keycode; m_pend_vld = 1'b1; end
        else m_comm = 8'h00;
      end else begin
        ev = {2'b01, keycode}; m_comm = keycode; m_cedge = edge_cnt;
      end
    end else if (RPT_ON && m_comm != 8'h00) begin
      t = edge_cnt - m_cedge;
      if (t >= RD && ((t - RD) % RP) == 0) begin
        push = 1'b1; ev = {2'b11, m_comm};
      end
    end
    ok = (q.size() < DEPTH) || pop;
    if (pop) void'(q.pop_front());
    if (push && ok) q.push_back(ev);
    if (push && !ok) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    edge_cnt++;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_valid"}, 32'(evt_valid), 32'(q.size() > 0));
    check_val({tag, "_level"}, 32'(fifo_level), 32'(q.size()));
    check_val({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    check_val({tag, "_held"},  32'(held_code),  32'(m_comm));
    if (q.size() > 0) begin
      check_val({tag, "_code"},  32'(evt_code),   32'(q[0][7:0]));
      check_val({tag, "_press"}, 32'(evt_press),  32'(q[0][8]));
      check_val({tag, "_rpt"},   32'(evt_repeat), 32'(q[0][9]));
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step(input string tag, input logic [7:0] k, input logic r, input logic c);
    keycode   = k;
    evt_ready = r;
    ovf_clr   = c;
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic hold(input string tag, input logic [7:0] k, input logic r, input int n);
    for (int i = 0; i < n; i++) step(tag, k, r, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(evt_valid),  32'd0);
    check_val({tag, "_code"},  32'(evt_code),   32'd0);
    check_val({tag, "_press"}, 32'(evt_press),  32'd0);
    check_val({tag, "_rpt"},   32'(evt_repeat), 32'd0);
    check_val({tag, "_held"},  32'(held_code),  32'd0);
    check_val({tag, "_level"}, 32'(fifo_level), 32'd0);
    check_val({tag, "_ovf"},   32'(overflow),   32'd0);
  endtask

  logic [7:0] keys [5];
  logic [7:0] rk;
  int         rhold;

  initial begin
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h09; keys[4] = 8'h1A;
    reset_n = 1'b0; keycode = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Single press, visible the cycle after the change edge.
    hold("idle", 8'h00, 1'b0, 2);
    step("t1", 8'h1A, 1'b0, 1'b0);
    check_val("t1_evt", {22'd0, evt_press, evt_code, evt_valid}, {22'd0, 1'b1, 8'h1A, 1'b1});
    check_val("t1_held_code", 32'(held_code), 32'h1A);
    hold("t1_drain", 8'h00, 1'b1, 4);

    // Ordered queueing with the consumer stalled.
    hold("t2a", 8'h04, 1'b0, 3);
    hold("t2b", 8'h07, 1'b0, 3);
    hold("t2c", 8'h00, 1'b0, 3);
    check_val("t2_level4", 32'(fifo_level), 32'd4);

    // Overflow: two more events dropped, clear, then pop+push while full.
    hold("t3a", 8'h05, 1'b0, 2);
    hold("t3b", 8'h00, 1'b0, 2);
    check_val("t3_ovf_set", 32'(overflow), 32'd1);
    step("t3_clr", 8'h00, 1'b0, 1'b1);
    check_val("t3_ovf_clr", 32'(overflow), 32'd0);
    step("t3_pp", 8'h09, 1'b1, 1'b0);
    check_val("t3_pp_level", 32'(fifo_level), 32'd4);
    check_val("t3_pp_noovf", 32'(overflow), 32'd0);
    hold("t3_drain", 8'h00, 1'b1, 8);

    // Rapid changes on consecutive cycles.
    step("t4a", 8'h04, 1'b1, 1'b0);
    step("t4b", 8'h07, 1'b1, 1'b0);
    step("t4c", 8'h09, 1'b1, 1'b0);
    hold("t4d", 8'h09, 1'b1, 4);
    hold("t4e", 8'h00, 1'b1, 3);

    // Long holds exercise auto-repeat timing when enabled.
    hold("t5a", 8'h1A, 1'b1, 30);
    hold("t5b", 8'h1B, 1'b1, 20);
    hold("t5c", 8'h00, 1'b1, 3);

    // Random keys, hold times, consumer stalls and overflow clears.
    for (int n = 0; n < 150; n++) begin
      rk    = keys[$urandom_range(0, 4)];
      rhold = $urandom_range(1, 20);
      for (int i = 0; i < rhold; i++)
        step("rnd", rk, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    hold("pre6", 8'h00, 1'b1, 8);

    // Reset mid-operation with three events queued and 0x16 held.
    step("t6a", 8'h05, 1'b0, 1'b0);
    hold("t6b", 8'h16, 1'b0, 3);
    check_val("t6_level3", 32'(fifo_level), 32'd3);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step("t6_post", 8'h16, 1'b0, 1'b0);
    check_val("t6_one", {23'd0, evt_press, evt_code}, {23'd0, 1'b1, 8'h16});
    check_val("t6_lvl1", 32'(fifo_level), 32'd1);
    hold("t6_tail", 8'h16, 1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
